qar_dmem_arbiter: RTL and testbench
===================================

QAR_DMEM_ARBITER -- requirements
Module: qar_dmem_arbiter

Interface
REQ-001 SHALL have parameter: DEPTH, 64, data memory size in 32-bit words (power of two, 16..4096).
REQ-002 SHALL have parameter: STARVE_MAX, 4, maximum consecutive core grants while DMA waits (1..15).
REQ-003 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: c_req_valid in 1, c_req_ready out 1, c_req_addr in 32 (byte address), c_req_wdata in 32, c_req_we in 1; this is the core load/store request.
REQ-006 SHALL have ports: c_rsp_valid out 1, c_rsp_rdata out 32, c_rsp_err out 1; this is the core response and has no backpressure.
REQ-007 SHALL have ports: d_req_valid, d_req_ready, d_req_addr, d_req_wdata, d_req_we, d_rsp_valid, d_rsp_rdata, d_rsp_err; these are the DMA/debug equivalents with identical widths.
REQ-008 SHALL have ports: mem_en out 1, mem_we out 1, mem_addr out $clog2(DEPTH) (word index), mem_wdata out 32, mem_rdata in 32; this is the single-port SRAM, which returns read data one cycle after mem_en.

Function
REQ-009 SHALL accept at most one request per cycle; accept = req_valid && req_ready.
REQ-010 SHALL drive req_ready combinationally, asserted only to the arbitration winner; a loser's ready SHALL be 0.
REQ-011 SHALL use arbitration with core priority over DMA, except that DMA wins when starve_cnt == STARVE_MAX and d_req_valid is high.
REQ-012 SHALL increment starve_cnt on each core accept while d_req_valid is high, and clear it on any DMA accept or whenever d_req_valid is low; starve_cnt SHALL saturate at STARVE_MAX.
REQ-013 SHALL compute the word index as addr[$clog2(DEPTH)+1:2]; an address is out of range if addr >= DEPTH*4 or addr[1:0] != 0.
REQ-014 SHALL register mem_en/mem_we/mem_addr/mem_wdata in cycle N+1 for an in-range request accepted in cycle N.
REQ-015 SHALL, for a read, assert rsp_valid to the originating port for exactly one cycle at N+2, with rsp_rdata = mem_rdata and rsp_err = 0.
REQ-016 SHALL, for a write, assert rsp_valid at N+2 with rsp_rdata = 0 and rsp_err = 0 (write acknowledge).
REQ-017 SHALL, for an out-of-range request, leave mem_en at 0 and assert rsp_valid at N+2 with rsp_err = 1 and rsp_rdata = 32'hDEAD_BEEF.
REQ-018 SHALL carry a 2-stage owner tag pipeline (valid, port id, we, err) so back-to-back accepts from either port yield responses in accept order, one per cycle.
REQ-019 SHALL NOT reorder a same-address write in cycle N followed by a read in cycle N+1; the read returns the written data.
REQ-020 SHALL hold rsp_rdata at 0 whenever rsp_valid is 0.
REQ-021 SHALL keep mem_en low and both ready outputs low when neither request valid is high.

Reset
REQ-022 SHALL, on rst assertion, immediately set all outputs to 0 (readies, mem_*, rsp_*), and clear starve_cnt, the RR pointer and the tag pipeline.
REQ-023 SHALL drop requests in flight at reset; no response is issued for them after reset release.
REQ-024 SHALL allow the first accept on the first rising clk edge after rst deasserts.

Configuration
REQ-025 SHALL, with macro QAR_DMEM_ARB_RR_EN defined, replace REQ-011/REQ-012 with round robin: a 1-bit pointer favours the port not most recently accepted, with reset value favouring core; starve_cnt is not implemented.
REQ-026 SHALL, without QAR_DMEM_ARB_RR_EN, behave per REQ-011/REQ-012, and DMA latency under continuous core traffic SHALL be <= STARVE_MAX+1 cycles.

Verification
REQ-027 SHALL verify: core write addr 0x40 data 0x0000_0123, then core read 0x40 -> c_rsp_valid at N+2 with rdata 0x0000_0123, err 0.
REQ-028 SHALL verify: core and DMA valid continuously, STARVE_MAX=4, default build -> accept pattern C,C,C,C,D repeating.
REQ-029 SHALL verify: same stimulus as REQ-028 with QAR_DMEM_ARB_RR_EN -> accept pattern C,D,C,D, with the first accept from core.
REQ-030 SHALL verify: DMA read addr 0x102 (misaligned) and addr DEPTH*4 -> mem_en stays 0, d_rsp_err=1, rdata 0xDEAD_BEEF.
REQ-031 SHALL verify: rst asserted one cycle after a core read accept -> c_rsp_valid never asserts for that read and all outputs are 0 during reset.
REQ-032 SHALL verify: random 1000-request mix on both ports against a reference memory model -> every response matches the model in accept order.

Source files
------------

// File: rtl/qar_dmem_arbiter.sv
// qar_dmem_arbiter: two-port (core / DMA) arbiter in front of a single-port
// data SRAM. Requests accepted in cycle N drive the SRAM in N+1 and respond
// in N+2 through a 2-stage owner tag pipeline, so responses stay in accept order.
// Optional build macro: QAR_DMEM_ARB_RR_EN replaces core-priority-with-starvation
// arbitration by a 1-bit round-robin pointer.
module qar_dmem_arbiter #(
  parameter int DEPTH      = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     c_req_valid,
  output logic                     c_req_ready,
  input  logic [31:0]              c_req_addr,
  input  logic [31:0]              c_req_wdata,
  input  logic                     c_req_we,
  output logic                     c_rsp_valid,
  output logic [31:0]              c_rsp_rdata,
  output logic                     c_rsp_err,
  input  logic                     d_req_valid,
  output logic                     d_req_ready,
  input  logic [31:0]              d_req_addr,
  input  logic [31:0]              d_req_wdata,
  input  logic                     d_req_we,
  output logic                     d_rsp_valid,
  output logic [31:0]              d_rsp_rdata,
  output logic                     d_rsp_err,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata
);
  localparam int AW     = $clog2(DEPTH);
  localparam int STAGES = 2;

  typedef struct packed {
    logic port;  // 0 = core, 1 = DMA
    logic we;
    logic err;
  } tag_t;

  logic core_win, dma_win, acc, oor;
  logic [31:0] sel_addr, sel_wdata, rsp_data;
  logic sel_we;
  tag_t tag_in, tag_out;
  logic [STAGES:1] vld_pipe;
  tag_t [STAGES:1] tag_pipe;

`ifdef QAR_DMEM_ARB_RR_EN
  // rr_ptr = 1 means DMA is favoured (core was accepted last)
  logic rr_ptr;

  // Winner selection: pointer breaks ties only when both ports request
  always_comb begin
    core_win = c_req_valid && !(d_req_valid && rr_ptr);
    dma_win  = d_req_valid && !core_win;
  end

  // Pointer moves away from whichever port was just accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           rr_ptr <= 1'b0;
    else if (core_win) rr_ptr <= 1'b1;
    else if (dma_win)  rr_ptr <= 1'b0;
  end
`else
  logic [3:0] starve_cnt;
  logic       starve;

  // Core has priority unless DMA has waited through STARVE_MAX core grants
  always_comb begin
    starve   = d_req_valid && (starve_cnt == 4'(STARVE_MAX));
    core_win = c_req_valid && !starve;
    dma_win  = d_req_valid && !core_win;
  end

  // Count core grants while DMA waits; saturates at STARVE_MAX
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          starve_cnt <= '0;
    else if (!d_req_valid || dma_win)                 starve_cnt <= '0;
    else if (core_win && starve_cnt != 4'(STARVE_MAX)) starve_cnt <= starve_cnt + 4'd1;
  end
`endif

  assign c_req_ready = core_win & ~rst;
  assign d_req_ready = dma_win & ~rst;

  // Mux the winning request and classify its address
  always_comb begin
    acc       = core_win | dma_win;
    sel_addr  = core_win ? c_req_addr  : d_req_addr;
    sel_wdata = core_win ? c_req_wdata : d_req_wdata;
    sel_we    = core_win ? c_req_we    : d_req_we;
    oor       = (sel_addr >= 32'(DEPTH * 4)) || (sel_addr[1:0] != 2'b00);
    tag_in    = '{port: dma_win, we: sel_we, err: oor};
  end

  // SRAM command stage and owner tag shift register; reset drops in-flight work
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      tag_pipe  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], acc};
      tag_pipe <= {tag_pipe[STAGES-1:1], tag_in};
      if (acc && !oor) begin
        mem_en    <= 1'b1;
        mem_we    <= sel_we;
        mem_addr  <= sel_addr[AW+1:2];
        mem_wdata <= sel_wdata;
      end else begin
        mem_en    <= 1'b0;
        mem_we    <= 1'b0;
        mem_addr  <= '0;
        mem_wdata <= '0;
      end
    end
  end

  // Response steering: SRAM data arrives the cycle the tag reaches the last stage
  always_comb begin
    tag_out     = tag_pipe[STAGES];
    rsp_data    = tag_out.err ? 32'hDEAD_BEEF : (tag_out.we ? 32'h0 : mem_rdata);
    c_rsp_valid = vld_pipe[STAGES] & ~tag_out.port;
    d_rsp_valid = vld_pipe[STAGES] &  tag_out.port;
    c_rsp_rdata = c_rsp_valid ? rsp_data : 32'h0;
    d_rsp_rdata = d_rsp_valid ? rsp_data : 32'h0;
    c_rsp_err   = c_rsp_valid & tag_out.err;
    d_rsp_err   = d_rsp_valid & tag_out.err;
  end
endmodule

// File: tb/tb_qar_dmem_arbiter.sv
// Scoreboard bench for qar_dmem_arbiter: the driver pushes expected responses
// at accept time, a negedge monitor pops and compares them.
module tb_qar_dmem_arbiter;
  localparam int DEPTH = 64;
  localparam int SMAX  = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic c_req_valid = 0, c_req_we = 0, d_req_valid = 0, d_req_we = 0;
  logic [31:0] c_req_addr = 0, c_req_wdata = 0, d_req_addr = 0, d_req_wdata = 0;
  logic c_req_ready, d_req_ready, c_rsp_valid, c_rsp_err, d_rsp_valid, d_rsp_err;
  logic [31:0] c_rsp_rdata, d_rsp_rdata, mem_wdata, mem_rdata;
  logic mem_en, mem_we;
  logic [5:0] mem_addr;

  qar_dmem_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_addr(c_req_addr),
    .c_req_wdata(c_req_wdata), .c_req_we(c_req_we),
    .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata), .c_rsp_err(c_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_we(d_req_we),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM behavioural model, preloaded on the first edge
  logic [31:0] sram [0:DEPTH-1];
  bit sram_init = 0;
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= 32'(i) * 32'h0101_0101 + 32'h100;
      sram_init <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  typedef struct { bit port; logic [31:0] data; bit err; int due; } exp_t;
  exp_t expq[$];
  logic [31:0] ref_mem [0:DEPTH-1];
  int n_chk = 0, n_err = 0, n_acc = 0;
  logic exp_men = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model update and expected-response push for one accept
  task automatic accept(input bit port, input logic [31:0] addr, input logic [31:0] wd, input bit we);
    exp_t e;
    bit oor;
    oor = (addr >= 32'(DEPTH * 4)) || (addr[1:0] != 2'b00);
    e.port = port; e.err = oor; e.due = cyc + 2;
    if (oor)     e.data = 32'hDEAD_BEEF;
    else if (we) e.data = 32'h0;
    else         e.data = ref_mem[addr[7:2]];
    if (!oor && we) ref_mem[addr[7:2]] = wd;
    if (!oor) exp_men = 1'b1;
    expq.push_back(e);
    n_acc++;
  endtask

  // One cycle of stimulus on both ports; reports which port was granted
  task automatic step(input bit cv, input logic [31:0] ca, input logic [31:0] cwd, input bit cwe,
                      input bit dv, input logic [31:0] da, input logic [31:0] dwd, input bit dwe,
                      output bit gc, output bit gd);
    bit ok;
    @(negedge clk);
    c_req_valid = cv; c_req_addr = ca; c_req_wdata = cwd; c_req_we = cwe;
    d_req_valid = dv; d_req_addr = da; d_req_wdata = dwd; d_req_we = dwe;
    #1;
    chk(mem_en == exp_men, "mem_en", 32'(mem_en), 32'(exp_men));
    ok = !(c_req_ready && d_req_ready) && (!c_req_ready || cv) && (!d_req_ready || dv)
         && ((cv || dv) == (c_req_ready || d_req_ready));
    chk(ok, "ready_rules", {30'd0, d_req_ready, c_req_ready}, {30'd0, dv, cv});
    gc = cv && c_req_ready;
    gd = dv && d_req_ready;
    exp_men = 1'b0;
    if (gc) accept(1'b0, ca, cwd, cwe);
    if (gd) accept(1'b1, da, dwd, dwe);
  endtask

  task automatic idle(input int n);
    bit gc, gd;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, gc, gd);
  endtask

  task automatic check_zero(input string name);
    logic [109:0] zv;
    zv = {c_req_ready, d_req_ready, mem_en, mem_we, mem_addr, mem_wdata, c_rsp_valid, c_rsp_rdata,
          c_rsp_err, d_rsp_valid, d_rsp_rdata, d_rsp_err};
    chk(zv == '0, name, 32'(zv != '0), 32'h0);
  endtask

  // Monitor: compare each presented response against the head of the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (!c_rsp_valid) chk(c_rsp_rdata == 0, "c_rdata_idle", c_rsp_rdata, 0);
      if (!d_rsp_valid) chk(d_rsp_rdata == 0, "d_rdata_idle", d_rsp_rdata, 0);
      if (c_rsp_valid || d_rsp_valid) begin
        if (expq.size() == 0) begin
          chk(1'b0, "unexpected_rsp", {30'd0, d_rsp_valid, c_rsp_valid}, 0);
        end else begin
          exp_t e;
          bit port;
          e = expq.pop_front();
          port = d_rsp_valid;
          chk(!(c_rsp_valid && d_rsp_valid) && port == e.port, "rsp_port",
              {30'd0, d_rsp_valid, c_rsp_valid}, e.port ? 32'd2 : 32'd1);
          chk(cyc == e.due, "rsp_latency", 32'(cyc), 32'(e.due));
          chk((port ? d_rsp_rdata : c_rsp_rdata) === e.data, "rsp_rdata",
              port ? d_rsp_rdata : c_rsp_rdata, e.data);
          chk((port ? d_rsp_err : c_rsp_err) == e.err, "rsp_err",
              32'(port ? d_rsp_err : c_rsp_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    bit gc, gd, cv, dv, cwe, dwe;
    logic [31:0] ca, da, cwd, dwd;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i) * 32'h0101_0101 + 32'h100;

    // Reset state, inputs quiet and then requesting
    #1 check_zero("reset_state");
    c_req_valid = 1; d_req_valid = 1;
    #1 check_zero("reset_readies");
    c_req_valid = 0; d_req_valid = 0;
    repeat (3) @(negedge clk);
    rst = 0;

    // Both ports requesting every cycle straight out of reset
    for (int i = 0; i < 15; i++) begin
      logic [1:0] expg;
`ifdef QAR_DMEM_ARB_RR_EN
      expg = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
      expg = (i % (SMAX + 1) == SMAX) ? 2'b10 : 2'b01;
`endif
      step(1, 32'h0, 0, 0, 1, 32'h4, 0, 0, gc, gd);
      chk({gd, gc} == expg, "arb_pattern", {30'd0, gd, gc}, {30'd0, expg});
    end
    idle(3);

    // Core write 0x40 then read back
    step(1, 32'h40, 32'h0000_0123, 1, 0, 0, 0, 0, gc, gd);
    step(1, 32'h40, 0, 0, 0, 0, 0, 0, gc, gd);
    idle(3);

    // DMA out-of-range: misaligned and one past the end; core misaligned in range
    step(0, 0, 0, 0, 1, 32'h102, 0, 0, gc, gd);
    step(0, 0, 0, 0, 1, 32'(DEPTH * 4), 0, 0, gc, gd);
    step(1, 32'h41, 0, 0, 0, 0, 0, 0, gc, gd);
    idle(3);

    // DMA write then core read of the same word on the next cycle
    step(0, 0, 0, 0, 1, 32'h10, 32'hCAFE_F00D, 1, gc, gd);
    step(1, 32'h10, 0, 0, 0, 0, 0, 0, gc, gd);
    idle(3);

    // Reset one cycle after a core read accept: its response must never appear
    step(1, 32'h8, 0, 0, 0, 0, 0, 0, gc, gd);
    chk(gc, "rst_test_accept", 32'(gc), 1);
    @(posedge clk); #1 c_req_valid = 0;
    @(posedge clk); #1 rst = 1;
    void'(expq.pop_back());
    c_req_valid = 1; d_req_valid = 1;
    #1 check_zero("reset_midflight");
    repeat (2) begin @(negedge clk); check_zero("reset_hold"); end
    @(negedge clk);
    rst = 0; c_req_valid = 0; d_req_valid = 0; exp_men = 1'b0;
    idle(4);

    // Random mix on both ports, bounded by a step budget
    for (int s = 0; s < 4000 && n_acc < 1100; s++) begin
      cv = 1'($urandom_range(0, 1)); dv = 1'($urandom_range(0, 1));
      cwe = 1'($urandom_range(0, 1)); dwe = 1'($urandom_range(0, 1));
      cwd = $urandom; dwd = $urandom;
      ca = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 15)) << 2;
      da = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 15)) << 2;
      step(cv, ca, cwd, cwe, dv, da, dwd, dwe, gc, gd);
    end
    idle(4);
    chk(expq.size() == 0, "drain", 32'(expq.size()), 0);
    chk(n_acc >= 1000, "random_count", 32'(n_acc), 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
